// File: rtl/aes_pkg.sv
// Shared AES definitions: constants, S-box tables, round constants,
// GF(2^8) helpers and the forward key-expansion step.
package aes_pkg;

   localparam int AES_NK = 4;
   localparam int AES_NR = 10;

   typedef logic [127:0] state_t;
   typedef logic [31:0]  word_t;

   typedef enum logic [1:0] {K_IDLE, K_EXPAND, K_READY} key_state_t;
   typedef enum logic [1:0] {C_IDLE, C_ROUND, C_FINAL} cipher_state_t;

   localparam logic [0:255][7:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [0:255][7:0] INV_SBOX_TBL = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   // Rcon[1..10]; only the leading byte of each Rcon word is non-zero
   localparam logic [1:10][7:0] RCON = {
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TBL[x];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      return INV_SBOX_TBL[x];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      if (i >= 4'd1 && i <= 4'd10) return RCON[i];
      return 8'h00;
   endfunction

   // Multiply by x in GF(2^8) modulo 0x11B
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // One step of the forward key schedule: rk[i] from rk[i-1]
   function automatic state_t expand_key(input state_t prev, input logic [7:0] rc);
      word_t w0, w1, w2, w3, t;
      w0 = prev[127:96];
      w1 = prev[95:64];
      w2 = prev[63:32];
      w3 = prev[31:0];
      t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when i_last).
module aes_inv_round
   import aes_pkg::*;
(
   input  state_t i_state,
   input  state_t i_round_key,
   input  logic   i_last,
   output state_t o_state
);

   state_t w_sub;
   state_t w_add;
   state_t w_mix;

   // Row r is rotated right by r columns while substituting each byte
   always_comb begin
      w_sub = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            w_sub[127 - 8*(4*c + r) -: 8] =
               inv_sbox(i_state[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]);
         end
      end
   end

   // Round key addition
   always_comb begin
      w_add = w_sub ^ i_round_key;
   end

   // Column-wise multiply by the inverse MixColumns matrix {0e,0b,0d,09}
   always_comb begin
      logic [7:0] a0, a1, a2, a3;
      w_mix = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = w_add[127 - 32*c -: 8];
         a1 = w_add[119 - 32*c -: 8];
         a2 = w_add[111 - 32*c -: 8];
         a3 = w_add[103 - 32*c -: 8];
         w_mix[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         w_mix[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         w_mix[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         w_mix[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
   end

   // The final round has no InvMixColumns
   always_comb begin
      o_state = i_last ? w_add : w_mix;
   end

endmodule

// File: rtl/aes_decrypt128_iterative.sv
// Iterative AES-128 inverse cipher. Round keys are expanded forward once per
// key load and held; each block then takes one round per clock.
module aes_decrypt128_iterative
   import aes_pkg::*;
#(
   parameter int Nk = AES_NK,
   parameter int Nr = AES_NR
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            key_load,
   input  logic [32*Nk-1:0] key,
   output logic            key_ready,
   input  logic            start,
   input  logic [127:0]    data,
   output logic            busy,
   output logic [127:0]    out,
   output logic            done
);

   key_state_t    r_kstate;
   key_state_t    w_kstate_nxt;
   cipher_state_t r_cstate;
   cipher_state_t w_cstate_nxt;

   state_t        r_rk [0:Nr];
   logic [3:0]    r_ki;
   logic [3:0]    w_ki_prev;
   state_t        w_rk_new;

   state_t        r_state;
   logic [3:0]    r_rnd;
   state_t        r_out;
   logic          r_done;

   state_t        w_rk_sel;
   logic          w_last;
   state_t        w_round_out;

   logic          w_key_load_acc;
   logic          w_start_acc;

   assign key_ready = (r_kstate == K_READY);
   assign busy      = (r_cstate != C_IDLE);
   assign out       = r_out;
   assign done      = r_done;

   // A key load never disturbs an in-flight block; a simultaneous start loses to it
   assign w_key_load_acc = key_load && !busy;
   assign w_start_acc    = (r_cstate == C_IDLE) && start && key_ready && !key_load;

   assign w_ki_prev = r_ki - 4'd1;
   assign w_rk_new  = expand_key(r_rk[w_ki_prev], rcon(r_ki));

   // The final round uses rk[0]; every other round uses rk[r]
   assign w_last   = (r_cstate == C_FINAL);
   assign w_rk_sel = w_last ? r_rk[0] : r_rk[r_rnd];

   aes_inv_round u_inv_round (
      .i_state     (r_state),
      .i_round_key (w_rk_sel),
      .i_last      (w_last),
      .o_state     (w_round_out)
   );

   // Key FSM next state: expand until rk[Nr] is written
   always_comb begin
      w_kstate_nxt = r_kstate;
      if (w_key_load_acc) begin
         w_kstate_nxt = K_EXPAND;
      end else if (r_kstate == K_EXPAND && r_ki == 4'(Nr)) begin
         w_kstate_nxt = K_READY;
      end
   end

   // Cipher FSM next state: initial AddRoundKey, Nr-1 full rounds, final round
   always_comb begin
      w_cstate_nxt = r_cstate;
      case (r_cstate)
         C_IDLE:  if (w_start_acc) w_cstate_nxt = C_ROUND;
         C_ROUND: if (r_rnd == 4'd1) w_cstate_nxt = C_FINAL;
         C_FINAL: w_cstate_nxt = C_IDLE;
         default: w_cstate_nxt = C_IDLE;
      endcase
   end

   // FSM state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_kstate <= K_IDLE;
         r_cstate <= C_IDLE;
      end else begin
         r_kstate <= w_kstate_nxt;
         r_cstate <= w_cstate_nxt;
      end
   end

   // Round-key storage: capture rk[0] on load, then one new round key per cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i <= Nr; i++) r_rk[i] <= '0;
         r_ki <= 4'd0;
      end else if (w_key_load_acc) begin
         r_rk[0] <= key;
         r_ki    <= 4'd1;
      end else if (r_kstate == K_EXPAND) begin
         r_rk[r_ki] <= w_rk_new;
         r_ki       <= r_ki + 4'd1;
      end
   end

   // Block datapath: working state, round counter, held plaintext and done pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= '0;
         r_rnd   <= 4'd0;
         r_out   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_cstate)
            C_IDLE: begin
               if (w_start_acc) begin
                  r_state <= data ^ r_rk[Nr];
                  r_rnd   <= 4'(Nr - 1);
               end
            end
            C_ROUND: begin
               r_state <= w_round_out;
               if (r_rnd != 4'd1) r_rnd <= r_rnd - 4'd1;
            end
            C_FINAL: begin
               r_out  <= w_round_out;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_decrypt128_iterative.sv
// Directed bench for the iterative AES-128 decryptor using FIPS-197 vectors.
module tb_aes_decrypt128_iterative;

   logic         clk      = 1'b0;
   logic         reset    = 1'b0;
   logic         key_load = 1'b0;
   logic [127:0] key      = '0;
   logic         key_ready;
   logic         start    = 1'b0;
   logic [127:0] data     = '0;
   logic         busy;
   logic [127:0] out_pt;
   logic         done;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [127:0] K_C1    = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_C1   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] RK10_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] K_B     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] RK10_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   aes_decrypt128_iterative dut (
      .clk       (clk),
      .reset     (reset),
      .key_load  (key_load),
      .key       (key),
      .key_ready (key_ready),
      .start     (start),
      .data      (data),
      .busy      (busy),
      .out       (out_pt),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Returns the number of cycles from the key_load edge until key_ready is seen
   task automatic load_key(input logic [127:0] k, output int lat);
      key      = k;
      key_load = 1'b1;
      @(negedge clk);
      key_load = 1'b0;
      lat = 0;
      while (!key_ready && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic count_done(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (done) cnt++;
      end
   endtask

   task automatic decrypt(input string tag, input logic [127:0] ct, input logic [127:0] pt);
      int lat;
      data  = ct;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy"}, 128'(busy), 128'd1);
      wait_done(lat);
      check({tag, "_latency"}, 128'(lat), 128'd10);
      check({tag, "_out"}, out_pt, pt);
      @(negedge clk);
      check({tag, "_done_pulse"}, 128'(done), 128'd0);
   endtask

   initial begin
      int lat;
      int cnt;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_key_ready", 128'(key_ready), 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_done", 128'(done), 128'd0);
      check("rst_out", out_pt, 128'd0);
      reset = 1'b1;
      @(negedge clk);

      // Start with no key is dropped
      data  = CT_C1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("nokey_busy", 128'(busy), 128'd0);
      count_done(14, cnt);
      check("nokey_done", 128'(cnt), 128'd0);

      // FIPS-197 C.1
      load_key(K_C1, lat);
      check("c1_key_latency", 128'(lat), 128'd10);
      check("c1_rk10", dut.r_rk[10], RK10_C1);
      decrypt("c1", CT_C1, PT_C1);

      // Back-to-back: start issued in the done cycle is accepted
      data  = CT_C1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat);
      check("b2b_first_latency", 128'(lat), 128'd10);
      check("b2b_first_out", out_pt, PT_C1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b_second_busy", 128'(busy), 128'd1);
      check("b2b_second_done_low", 128'(done), 128'd0);
      wait_done(lat);
      check("b2b_second_latency", 128'(lat), 128'd10);
      check("b2b_second_out", out_pt, PT_C1);
      @(negedge clk);

      // FIPS-197 App. B after key reload
      load_key(K_B, lat);
      check("b_key_latency", 128'(lat), 128'd10);
      check("b_rk10", dut.r_rk[10], RK10_B);
      decrypt("b", CT_B, PT_B);

      // Second start mid-block is ignored
      data  = CT_B;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      data  = CT_C1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      count_done(20, cnt);
      check("midstart_done_count", 128'(cnt), 128'd1);
      check("midstart_out", out_pt, PT_B);

      // key_load while busy is ignored
      data  = CT_B;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      key      = K_C1;
      key_load = 1'b1;
      @(negedge clk);
      key_load = 1'b0;
      wait_done(lat);
      check("busyload_out", out_pt, PT_B);
      check("busyload_key_ready", 128'(key_ready), 128'd1);
      check("busyload_rk10", dut.r_rk[10], RK10_B);
      @(negedge clk);

      // key_load at expansion cycle 5 restarts expansion
      key      = K_B;
      key_load = 1'b1;
      @(negedge clk);
      key_load = 1'b0;
      repeat (4) @(negedge clk);
      key      = K_C1;
      key_load = 1'b1;
      @(negedge clk);
      key_load = 1'b0;
      repeat (5) @(negedge clk);
      check("restart_not_ready_yet", 128'(key_ready), 128'd0);
      lat = 0;
      while (!key_ready && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("restart_ready_delay", 128'(lat), 128'd5);
      check("restart_rk10", dut.r_rk[10], RK10_C1);
      decrypt("restart_c1", CT_C1, PT_C1);

      // Reset during round 5 aborts the block
      data  = CT_C1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_busy", 128'(busy), 128'd0);
      check("abort_done", 128'(done), 128'd0);
      check("abort_out", out_pt, 128'd0);
      check("abort_key_ready", 128'(key_ready), 128'd0);
      check("abort_rk10", dut.r_rk[10], 128'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      count_done(15, cnt);
      check("abort_no_done", 128'(cnt), 128'd0);
      load_key(K_C1, lat);
      check("post_reset_key_latency", 128'(lat), 128'd10);
      decrypt("post_reset_c1", CT_C1, PT_C1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
